contador_programable: RTL and testbench
=======================================

// Module: contador_programable
// PURPOSE
//  Parametrised up/down event counter; next generation of the team's basic reset/enable counter.
//  Adds modulo limit, direction, parallel load, wrap/saturate/one-shot modes, level/edge event
//  qualification, terminal-count pulse and done/busy status for the control FSM. Sits between
//  datapath event sources and the control state machine; all logic on rising edge of clk.
// PARAMETERS
//  WIDTH      6                counter register width in bits (out is [WIDTH-1:0])
//  MAX_COUNT  (1<<WIDTH)-1     terminal value; legal range 1..2**WIDTH-1
//  MODE       0                0 = WRAP, 1 = SATURATE, 2 = ONESHOT
//  EDGE_MODE  0                0 = count every cycle cnt_en=1; 1 = count rising edges of cnt_en
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  reset     in   1      synchronous, active-high; highest priority
//  cnt_en    in   1      count event request (qualified per EDGE_MODE)
//  up_dn     in   1      1 = count up, 0 = count down; sampled with each event
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  value to load; values > MAX_COUNT are clamped to MAX_COUNT
//  start     in   1      ONESHOT only: arm a run; ignored in other modes
//  out       out  WIDTH  registered count value
//  zero      out  1      combinational, 1 when out == 0
//  tc        out  1      registered 1-cycle terminal-count pulse
//  busy      out  1      registered, 1 while FSM in RUN
//  done      out  1      registered, 1 while FSM in DONE (ONESHOT only)
// BEHAVIOUR
//  - reset: out=0, tc=0, edge history=0. FSM -> IDLE if MODE=2, else RUN. busy=(MODE!=2), done=0.
//  - evt = EDGE_MODE ? (cnt_en & ~cnt_en_q) : cnt_en. cnt_en_q is registered; the edge counts in the same cycle.
//  - term = up_dn ? (out==MAX_COUNT) : (out==0). Count applies only in RUN.
//  - Priority per cycle: reset > load > start > evt. Load with evt in the same cycle: load wins, event dropped.
//  - load: out <= min(load_val, MAX_COUNT). FSM state unchanged. tc=0.
//  - evt & !term: out <= out +/- 1. tc=0.
//  - evt & term, WRAP: out <= up ? 0 : MAX_COUNT. tc=1 in the next cycle.
//  - evt & term, SATURATE: out holds. tc=1 for every blocked event.
//  - evt & term, ONESHOT: out holds; FSM RUN->DONE; tc=1.
//  - FSM (ONESHOT): IDLE --start--> RUN; RUN --evt&term--> DONE; DONE --start--> RUN; start in RUN ignored.
//    On start: out <= up_dn ? 0 : MAX_COUNT. A run therefore consumes MAX_COUNT+1 events.
//  - FSM (WRAP/SAT): permanently RUN after reset.
//  - tc never high for two consecutive cycles unless events occur on consecutive cycles at term.
//  - No arithmetic overflow: out is always in 0..MAX_COUNT. A change of up_dn mid-count takes effect on the next event.
//  - reset mid-run: all outputs return to reset values next cycle; a pending edge is lost.
// STRUCTURE
//  - Shared package contador_pkg: MODE_WRAP/MODE_SAT/MODE_ONESHOT constants; FSM state encoding
//    ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  - Sub-module detector_flanco: 1-bit rising-edge detector (clk, reset, d -> pulse). Instantiated
//    when EDGE_MODE=1. Top holds the counter register, FSM and tc/status registers.
// TESTING
//  1. WIDTH=6, WRAP, up, cnt_en=1 for 64 cycles from reset -> out 0..63 then 0; tc=1 exactly once (cycle after 63->0); zero=1 at 0.
//  2. WRAP, down from 0, one event -> out=63, tc=1; SATURATE, up, load 62, 3 events -> out 63,63,63; tc pulses on events 2 and 3.
//  3. load=1 with load_val=70 and MAX_COUNT=50 -> out=50. Load and evt in the same cycle with out=5, load_val=20 -> out=20, not 21.
//  4. ONESHOT, MAX_COUNT=9: start, then 10 events -> out 0..9, DONE after 10th, done=1, busy=0, tc=1 once. Further events -> out stays 9.
//  5. EDGE_MODE=1: cnt_en held high 8 cycles -> out increments by exactly 1. cnt_en toggling 1010.. over 8 cycles -> +4.
//  6. ONESHOT reset asserted while out=4 in RUN -> next cycle out=0, state IDLE, busy=0, done=0, tc=0. Events then ignored until start.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared constants for the programmable counter: operating modes and FSM states.
package contador_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_ONESHOT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/detector_flanco.sv
// Single-bit rising-edge detector; pulse is high in the same cycle d rises.
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/contador_programable.sv
// Up/down event counter with modulo limit, parallel load, wrap/saturate/one-shot
// modes, optional edge qualification of events, terminal-count pulse and status.
module contador_programable
  import contador_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int MAX_COUNT = (1 << WIDTH) - 1,
  parameter int MODE      = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);
  localparam estado_t          RESET_ST = (MODE == MODE_ONESHOT) ? ST_IDLE : ST_RUN;

  logic             evt;
  logic             term;
  logic             tc_next;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] load_clamped;
  estado_t          state, state_next;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      detector_flanco u_detector (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_en),
        .pulse (evt)
      );
    end else begin : g_level
      assign evt = cnt_en;
    end
  endgenerate

  assign term         = up_dn ? (out == MAX_V) : (out == '0);
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
  assign zero         = (out == '0);

  // Start is only honoured outside RUN, so it never competes with a counted event.
  always_comb begin
    state_next = state;
    out_next   = out;
    tc_next    = 1'b0;
    if (load) begin
      out_next = load_clamped;
    end else if ((MODE == MODE_ONESHOT) && start && (state != ST_RUN)) begin
      state_next = ST_RUN;
      out_next   = up_dn ? '0 : MAX_V;
    end else if (evt && (state == ST_RUN)) begin
      if (!term) begin
        out_next = up_dn ? (out + ONE_V) : (out - ONE_V);
      end else begin
        tc_next = 1'b1;
        if (MODE == MODE_WRAP)         out_next   = up_dn ? '0 : MAX_V;
        else if (MODE == MODE_ONESHOT) state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_ST;
      out   <= '0;
      tc    <= 1'b0;
      busy  <= (RESET_ST == ST_RUN);
      done  <= 1'b0;
    end else begin
      state <= state_next;
      out   <= out_next;
      tc    <= tc_next;
      busy  <= (state_next == ST_RUN);
      done  <= (state_next == ST_DONE);
    end
  end

endmodule

// File: tb/tb_contador_programable.sv
// Bench for contador_programable: five configurations share one stimulus stream.
module tb_contador_programable;

  localparam int N = 5;
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0, cnt_en = 1'b0, up_dn = 1'b0, load = 1'b0, start = 1'b0;
  logic [7:0] load_val = '0;

  logic [5:0] out0, out1, out3, out4;
  logic [6:0] out2;
  logic z0, z1, z2, z3, z4, t0, t1, t2, t3, t4;
  logic b0, b1, b2, b3, b4, d0, d1, d2, d3, d4;

  // 0: wrap 63, 1: saturate 63, 2: wrap 50 (7 bit), 3: one-shot 9, 4: edge wrap 63
  contador_programable #(.WIDTH(6), .MAX_COUNT(63), .MODE(0), .EDGE_MODE(0)) u_wrap (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val[5:0]), .start(start), .out(out0), .zero(z0), .tc(t0), .busy(b0), .done(d0));
  contador_programable #(.WIDTH(6), .MAX_COUNT(63), .MODE(1), .EDGE_MODE(0)) u_sat (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val[5:0]), .start(start), .out(out1), .zero(z1), .tc(t1), .busy(b1), .done(d1));
  contador_programable #(.WIDTH(7), .MAX_COUNT(50), .MODE(0), .EDGE_MODE(0)) u_lim (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val[6:0]), .start(start), .out(out2), .zero(z2), .tc(t2), .busy(b2), .done(d2));
  contador_programable #(.WIDTH(6), .MAX_COUNT(9), .MODE(2), .EDGE_MODE(0)) u_one (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val[5:0]), .start(start), .out(out3), .zero(z3), .tc(t3), .busy(b3), .done(d3));
  contador_programable #(.WIDTH(6), .MAX_COUNT(63), .MODE(0), .EDGE_MODE(1)) u_edge (
    .clk(clk), .reset(reset), .cnt_en(cnt_en), .up_dn(up_dn), .load(load),
    .load_val(load_val[5:0]), .start(start), .out(out4), .zero(z4), .tc(t4), .busy(b4), .done(d4));

  int cfg_w[N]    = '{6, 6, 7, 6, 6};
  int cfg_max[N]  = '{63, 63, 50, 9, 63};
  int cfg_mode[N] = '{0, 1, 0, 2, 0};
  int cfg_edge[N] = '{0, 0, 0, 0, 1};

  int m_out[N];
  int m_ph[N];
  bit m_tc[N];
  bit m_prev[N];

  int tests = 0;
  int fails = 0;

  function automatic int g_out(int i);
    case (i)
      0: return int'(out0);
      1: return int'(out1);
      2: return int'(out2);
      3: return int'(out3);
      default: return int'(out4);
    endcase
  endfunction

  function automatic int g_bit(int i, int which);
    logic [4:0] v;
    case (which)
      0: v = {z4, z3, z2, z1, z0};
      1: v = {t4, t3, t2, t1, t0};
      2: v = {b4, b3, b2, b1, b0};
      default: v = {d4, d3, d2, d1, d0};
    endcase
    return int'(v[i]);
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int i, int eo, int etc, int eb, int ed);
    chk($sformatf("%s[%0d].out", tag, i), g_out(i), eo);
    chk($sformatf("%s[%0d].zero", tag, i), g_bit(i, 0), (eo == 0) ? 1 : 0);
    chk($sformatf("%s[%0d].tc", tag, i), g_bit(i, 1), etc);
    chk($sformatf("%s[%0d].busy", tag, i), g_bit(i, 2), eb);
    chk($sformatf("%s[%0d].done", tag, i), g_bit(i, 3), ed);
  endtask

  // Reference model: applies the mode rules directly to an integer count and a phase.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int  mx, lv;
      bit  evt, at_term;
      mx = cfg_max[i];
      lv = int'(load_val) % (1 << cfg_w[i]);
      if (reset) begin
        m_out[i] = 0; m_tc[i] = 0; m_prev[i] = 0;
        m_ph[i]  = (cfg_mode[i] == 2) ? P_IDLE : P_RUN;
        continue;
      end
      evt = (cfg_edge[i] != 0) ? (cnt_en && !m_prev[i]) : cnt_en;
      m_prev[i] = cnt_en;
      m_tc[i] = 0;
      if (load) begin
        m_out[i] = (lv > mx) ? mx : lv;
      end else if (cfg_mode[i] == 2 && start && m_ph[i] != P_RUN) begin
        m_ph[i]  = P_RUN;
        m_out[i] = up_dn ? 0 : mx;
      end else if (evt && m_ph[i] == P_RUN) begin
        at_term = up_dn ? (m_out[i] == mx) : (m_out[i] == 0);
        if (!at_term) begin
          m_out[i] = up_dn ? m_out[i] + 1 : m_out[i] - 1;
        end else begin
          m_tc[i] = 1;
          if (cfg_mode[i] == 0)      m_out[i] = up_dn ? 0 : mx;
          else if (cfg_mode[i] == 2) m_ph[i]  = P_DONE;
        end
      end
    end
  endtask

  typedef struct {
    bit rst, en, up, ld;
    int lv;
    bit st;
    int idx, eo;
    bit etc, eb, ed;
  } vec_t;

  vec_t vq[$];

  function automatic void add(bit rst, bit en, bit up, bit ld, int lv, bit st,
                              int idx, int eo, bit etc, bit eb, bit ed);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.ld = ld; v.lv = lv; v.st = st;
    v.idx = idx; v.eo = eo; v.etc = etc; v.eb = eb; v.ed = ed;
    vq.push_back(v);
  endfunction

  task automatic drive(bit rst, bit en, bit up, bit ld, int lv, bit st);
    reset = rst; cnt_en = en; up_dn = up; load = ld; load_val = 8'(lv); start = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tc_seen;

    // Wrap down from zero, then saturate up from 62
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 63, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 63, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 1, 62, 0, 1, 62, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 63, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 63, 1, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 63, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 1, 63, 0, 1, 0);
    // Load clamp and load-beats-event
    add(1, 0, 1, 0, 0, 0, 2, 0, 0, 1, 0);
    add(0, 0, 1, 1, 70, 0, 2, 50, 0, 1, 0);
    add(0, 0, 1, 1, 5, 0, 2, 5, 0, 1, 0);
    add(0, 1, 1, 1, 20, 0, 2, 20, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 2, 21, 0, 1, 0);
    // One-shot run of MAX_COUNT+1 events
    add(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 1, 0, 0, 0, 3, k, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 3, 9, 1, 0, 1);
    add(0, 1, 1, 0, 0, 0, 3, 9, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 3, 9, 0, 0, 1);
    // Edge qualification: toggling then holding high
    add(1, 0, 1, 0, 0, 0, 4, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) add(0, (k % 2) == 0, 1, 0, 0, 0, 4, k / 2 + 1, 0, 1, 0);
    for (int k = 0; k < 8; k++) add(0, 1, 1, 0, 0, 0, 4, 5, 0, 1, 0);
    // Reset mid one-shot run
    add(1, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) add(0, 1, 1, 0, 0, 0, 3, k, 0, 1, 0);
    add(1, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, 3, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 3, 1, 0, 1, 0);

    @(posedge clk);
    #1;
    foreach (vq[n]) begin
      drive(vq[n].rst, vq[n].en, vq[n].up, vq[n].ld, vq[n].lv, vq[n].st);
      chk_all($sformatf("vec%0d", n), vq[n].idx, vq[n].eo, vq[n].etc, vq[n].eb, vq[n].ed);
    end

    // Full up-count wrap on the 6-bit counter
    drive(1, 0, 1, 0, 0, 0);
    chk_all("t1_reset", 0, 0, 0, 1, 0);
    tc_seen = 0;
    for (int k = 1; k <= 64; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      chk($sformatf("t1_out_%0d", k), int'(out0), k % 64);
      chk($sformatf("t1_tc_%0d", k), int'(t0), (k == 64) ? 1 : 0);
      if (t0) tc_seen++;
    end
    chk("t1_zero_after_wrap", int'(z0), 1);
    drive(0, 0, 1, 0, 0, 0);
    chk("t1_tc_clears", int'(t0), 0);
    chk("t1_tc_count", tc_seen, 1);

    // Randomized run of all five configurations against the model
    begin
      bit dir = 1'b1;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(39) == 0) dir = ~dir;
        reset    = (c == 0) || ($urandom_range(299) == 0);
        cnt_en   = ($urandom_range(3) != 0);
        up_dn    = dir;
        load     = ($urandom_range(49) == 0);
        load_val = 8'($urandom_range(127));
        start    = ($urandom_range(19) == 0);
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < N; i++)
          chk_all($sformatf("rnd%0d", c), i, m_out[i], int'(m_tc[i]),
                  (m_ph[i] == P_RUN) ? 1 : 0, (m_ph[i] == P_DONE) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
